// File: rtl/requant_pkg.sv
// Shared widths, activation limits and the pipeline stage record for requant_unit.
package requant_pkg;

  localparam int ACC_W   = 16;
  localparam int MULT_W  = 16;
  localparam int SHIFT_W = 5;
  localparam int OUT_W   = 8;

  // Full-precision product width: (ACC_W+1)-bit sum times (MULT_W+1)-bit signed scale.
  localparam int PROD_W = ACC_W + MULT_W + 2;

  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  // One pipeline slot. Beat control travels with the data so config changes
  // between beats never affect beats that are already in flight.
  typedef struct packed {
    logic                      valid;
    logic                      last;
    logic                      relu;
    logic [SHIFT_W-1:0]        shift;
    logic signed [PROD_W-1:0]  data;
  } stage_t;

endpackage

// File: rtl/requant_if.sv
// Streaming accumulator-in / activation-out handshake bundle.
interface requant_if #(
  parameter int ACC_W = requant_pkg::ACC_W,
  parameter int OUT_W = requant_pkg::OUT_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [ACC_W-1:0]  in_acc;
  logic                     in_last;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_last;

  // Requantiser side: consumes accumulators, produces activations.
  modport slave (
    input  in_valid, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  // Producer/consumer side around the requantiser.
  modport master (
    output in_valid, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/requant_round_sat.sv
// Round-half-up arithmetic right shift, optional ReLU and int8 saturation.
// Purely combinational; sat flags results clipped at the activation bounds.
module requant_round_sat #(
  parameter int PROD_W  = requant_pkg::PROD_W,
  parameter int SHIFT_W = requant_pkg::SHIFT_W,
  parameter int OUT_W   = requant_pkg::OUT_W
) (
  input  logic signed [PROD_W-1:0] prod,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     relu,
  output logic signed [OUT_W-1:0]  result,
  output logic                     sat
);

  import requant_pkg::*;

  localparam logic signed [PROD_W:0] HI = (PROD_W+1)'(OUT_MAX);
  localparam logic signed [PROD_W:0] LO = (PROD_W+1)'(OUT_MIN);

  logic signed [PROD_W:0] wide;
  logic signed [PROD_W:0] rnd;
  logic signed [PROD_W:0] rsum;
  logic signed [PROD_W:0] r;

  // One extra bit keeps the rounding add from overflowing before the shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result = '0;
    sat    = 1'b0;
    wide   = {prod[PROD_W-1], prod};
    rnd    = '0;
    if (shift != '0) begin
      rnd = {{PROD_W{1'b0}}, 1'b1} << (shift - 1'b1);
    end
    rsum = wide + rnd;
    r    = rsum >>> shift;

    if (relu && r[PROD_W]) begin
      result = '0;
    end else if (r > HI) begin
      result = HI[OUT_W-1:0];
      sat    = 1'b1;
    end else if (r < LO) begin
      result = LO[OUT_W-1:0];
      sat    = 1'b1;
    end else begin
      result = r[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/requant_unit.sv
// Three-stage requantiser: S1 bias add, S2 scale multiply, S3 round/ReLU/saturate.
// Each stage loads when empty or when its contents move on, so bubbles collapse.
module requant_unit #(
  parameter int ACC_W   = requant_pkg::ACC_W,
  parameter int MULT_W  = requant_pkg::MULT_W,
  parameter int SHIFT_W = requant_pkg::SHIFT_W,
  parameter int OUT_W   = requant_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [ACC_W-1:0]  cfg_bias,
  input  logic [MULT_W-1:0]        cfg_mult,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic                     cfg_relu,
  input  logic                     clr_stats,
  requant_if.slave                 strm,
  output logic [15:0]              sat_count
);

  import requant_pkg::*;

  localparam int PROD_W = ACC_W + MULT_W + 2;

  stage_t                     s1_q;
  stage_t                     s2_q;
  logic [MULT_W-1:0]          s1_mult_q;
  logic                       s3_valid_q;
  logic signed [OUT_W-1:0]    s3_data_q;
  logic                       s3_last_q;
  logic [15:0]                sat_count_q;

  logic                       s1_en;
  logic                       s2_en;
  logic                       s3_en;
  logic                       accept;
  logic signed [ACC_W:0]      sum;
  logic signed [PROD_W-1:0]   mult_ext;
  logic signed [PROD_W-1:0]   prod;
  logic signed [OUT_W-1:0]    rs_result;
  logic                       rs_sat;

  // Load enables ripple back from the output: a full stage may still load
  // when the stage ahead of it is emptying in the same cycle.
  assign s3_en  = !s3_valid_q || strm.out_ready;
  assign s2_en  = !s2_q.valid || s3_en;
  assign s1_en  = !s1_q.valid || s2_en;
  assign strm.in_ready = s1_en && !rst;
  assign accept = strm.in_valid && strm.in_ready;

  assign sum      = {strm.in_acc[ACC_W-1], strm.in_acc} + {cfg_bias[ACC_W-1], cfg_bias};
  // The stored sum is sign-extended and the scale is non-negative, so the
  // truncated PROD_W-bit product is exact.
  assign mult_ext = PROD_W'({1'b0, s1_mult_q});
  assign prod     = s1_q.data * mult_ext;

  requant_round_sat #(
    .PROD_W  (PROD_W),
    .SHIFT_W (SHIFT_W),
    .OUT_W   (OUT_W)
  ) u_round_sat (
    .prod   (s2_q.data),
    .shift  (s2_q.shift),
    .relu   (s2_q.relu),
    .result (rs_result),
    .sat    (rs_sat)
  );

  // S1: capture the accepted beat with its bias-added sum and its config.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      s1_q      <= '0;
      s1_mult_q <= '0;
    end else if (s1_en) begin
      s1_q.valid <= accept;
      if (accept) begin
        s1_q.last  <= strm.in_last;
        s1_q.relu  <= cfg_relu;
        s1_q.shift <= cfg_shift;
        s1_q.data  <= PROD_W'(sum);
        s1_mult_q  <= cfg_mult;
      end
    end
  end

  // S2: apply the unsigned scale at full precision.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_q <= '0;
    end else if (s2_en) begin
      s2_q.valid <= s1_q.valid;
      if (s1_q.valid) begin
        s2_q.last  <= s1_q.last;
        s2_q.relu  <= s1_q.relu;
        s2_q.shift <= s1_q.shift;
        s2_q.data  <= prod;
      end
    end
  end

  // S3: output register; data holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
      s3_last_q  <= 1'b0;
    end else if (s3_en) begin
      s3_valid_q <= s2_q.valid;
      if (s2_q.valid) begin
        s3_data_q <= rs_result;
        s3_last_q <= s2_q.last;
      end
    end
  end

  // Saturation statistics: count clipped beats as they enter S3, stick at
  // full scale, and let a clear override a simultaneous increment.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      sat_count_q <= '0;
    end else if (s3_en && s2_q.valid && rs_sat && (sat_count_q != 16'hFFFF)) begin
      sat_count_q <= sat_count_q + 16'd1;
    end
  end

  assign strm.out_valid = s3_valid_q;
  assign strm.out_data  = s3_data_q;
  assign strm.out_last  = s3_last_q;
  assign sat_count      = sat_count_q;

endmodule

// File: tb/tb_requant_unit.sv
// Scoreboard bench for requant_unit: expected beats are queued on acceptance
// and compared in order as the DUT hands them over.
module tb_requant_unit;

  import requant_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic signed [ACC_W-1:0]   cfg_bias;
  logic [MULT_W-1:0]         cfg_mult;
  logic [SHIFT_W-1:0]        cfg_shift;
  logic                      cfg_relu;
  logic                      clr_stats;
  logic [15:0]               sat_count;

  requant_if #(.ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  requant_unit dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_bias  (cfg_bias),
    .cfg_mult  (cfg_mult),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .clr_stats (clr_stats),
    .strm      (bus),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [OUT_W-1:0] data;
    logic                    last;
    int                      acc_cyc;
    bit                      lat_chk;
  } exp_t;

  exp_t sb[$];

  int n_vec     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int ready_mode = 0;   // 0: always ready, 1: stalled, 2: random
  int model_sat = 0;

  // Pending config for the next beat, applied to the ports at the drive edge.
  logic signed [ACC_W-1:0] p_bias  = '0;
  logic [MULT_W-1:0]       p_mult  = 16'd1;
  logic [SHIFT_W-1:0]      p_shift = '0;
  logic                    p_relu  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: bias add, scale, round-half-up shift, ReLU, clip to int8.
  function automatic void model(input logic signed [ACC_W-1:0] acc,
                                input logic signed [ACC_W-1:0] bias,
                                input logic [MULT_W-1:0] mult,
                                input logic [SHIFT_W-1:0] shift,
                                input logic relu,
                                output logic signed [OUT_W-1:0] res,
                                output bit sat);
    longint s;
    longint p;
    longint r;
    s = longint'(acc) + longint'(bias);
    p = s * longint'(mult);
    if (shift == 0) r = p;
    else            r = (p + (longint'(1) << (shift - 1))) >>> shift;
    sat = 1'b0;
    if (relu && r < 0) begin
      res = '0;
    end else if (r > 127) begin
      res = 8'sd127;
      sat = 1'b1;
    end else if (r < -128) begin
      res = -8'sd128;
      sat = 1'b1;
    end else begin
      res = r[7:0];
    end
  endfunction

  // Present one beat from the falling edge and hold it until accepted.
  task automatic send(input logic signed [ACC_W-1:0] acc, input logic last);
    logic signed [OUT_W-1:0] er;
    bit   es;
    exp_t e;
    int   waitc;
    waitc = 0;
    @(negedge clk);
    cfg_bias  = p_bias;
    cfg_mult  = p_mult;
    cfg_shift = p_shift;
    cfg_relu  = p_relu;
    bus.in_valid = 1'b1;
    bus.in_acc   = acc;
    bus.in_last  = last;
    #1;
    while (!bus.in_ready) begin
      waitc++;
      if (waitc > 500) begin
        check("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    model(acc, p_bias, p_mult, p_shift, p_relu, er, es);
    if (es && model_sat < 65535) model_sat++;
    e.data    = er;
    e.last    = last;
    e.acc_cyc = cyc + 1;
    e.lat_chk = (ready_mode == 0);
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic signed [ACC_W-1:0] b, input logic [MULT_W-1:0] m,
                         input logic [SHIFT_W-1:0] s, input logic r);
    p_bias  = b;
    p_mult  = m;
    p_shift = s;
    p_relu  = r;
  endtask

  task automatic rand_beats(input int n);
    for (int i = 0; i < n; i++) begin
      set_cfg(16'($urandom), 16'($urandom), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      send(16'($urandom), 1'(i == n - 1));
    end
    idle();
  endtask

  // Output side: drive out_ready, then check holds and pop on each handshake.
  logic                    held_v = 1'b0;
  logic signed [OUT_W-1:0] held_data;
  logic                    held_last;

  always @(negedge clk) begin
    exp_t e;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    #2;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, held_data);
        check("hold_last", bus.out_last, held_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check("data", bus.out_data, e.data);
          check("last", bus.out_last, e.last);
          if (e.lat_chk) check("latency", cyc - e.acc_cyc, 2);
        end
      end
      held_v    = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      held_last = bus.out_last;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_acc    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    cfg_bias  = '0;
    cfg_mult  = 16'd1;
    cfg_shift = '0;
    cfg_relu  = 1'b0;
    clr_stats = 1'b0;

    // Reset state, and in_ready held low while reset is asserted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", bus.in_ready, 1);

    // Pass-through with saturation at both bounds.
    set_cfg(16'sd0, 16'd1, 5'd0, 1'b0);
    send(16'sd100, 1'b0);
    send(16'sd300, 1'b0);
    send(-16'sd300, 1'b1);
    idle();
    drain();
    check("sat_passthru", sat_count, model_sat);

    // Round half toward +inf.
    set_cfg(16'sd0, 16'd1, 5'd1, 1'b0);
    send(16'sd5, 1'b0);
    send(-16'sd5, 1'b0);
    send(-16'sd6, 1'b1);
    idle();
    drain();
    check("sat_round", sat_count, model_sat);

    // Scale and bias, in range then saturating.
    set_cfg(-16'sd50, 16'd16384, 5'd15, 1'b0);
    send(16'sd250, 1'b0);
    send(16'sd400, 1'b1);
    idle();
    drain();
    check("sat_scale", sat_count, model_sat);

    // ReLU clamps without counting; without ReLU the same beat saturates.
    set_cfg(16'sd0, 16'd1, 5'd0, 1'b1);
    send(-16'sd1000, 1'b0);
    set_cfg(16'sd0, 16'd1, 5'd0, 1'b0);
    send(-16'sd1000, 1'b1);
    idle();
    drain();
    check("sat_relu", sat_count, model_sat);

    // Random beats with per-beat config, downstream always ready.
    rand_beats(60);
    drain();
    check("sat_rand", sat_count, model_sat);

    // Backpressure: fill the pipe against a stalled output, then random ready.
    set_cfg(16'sd0, 16'd1, 5'd0, 1'b0);
    ready_mode = 1;
    send(16'sd1, 1'b0);
    send(16'sd2, 1'b0);
    send(16'sd3, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("full_in_ready", bus.in_ready, 0);
    ready_mode = 0;
    @(negedge clk);
    #1;
    check("full_accept_ready", bus.in_ready, 1);
    ready_mode = 2;
    for (int i = 4; i <= 8; i++) send(16'(i), 1'(i == 8));
    idle();
    drain();
    check("sat_bp", sat_count, model_sat);

    // Random beats against random backpressure.
    rand_beats(60);
    drain();
    check("sat_rand_bp", sat_count, model_sat);

    // One-cycle reset with three beats held in the pipe.
    set_cfg(16'sd0, 16'd1, 5'd0, 1'b0);
    ready_mode = 1;
    send(16'sd10, 1'b0);
    send(16'sd11, 1'b0);
    send(16'sd12, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("in_ready_in_rst", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb.delete();
    model_sat = 0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_sat_count", sat_count, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    ready_mode = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst_no_stale", bus.out_valid, 0);

    // Clear coinciding with a saturating beat entering S3.
    set_cfg(16'sd0, 16'd1, 5'd0, 1'b0);
    send(16'sd300, 1'b0);
    idle();
    drain();
    check("sat_before_clr", sat_count, model_sat);
    send(16'sd300, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    model_sat = 0;
    drain();
    check("sat_clr_wins", sat_count, model_sat);

    // Saturation counter sticks at full scale.
    for (int i = 0; i < 65540; i++) send(16'sd300, 1'(i == 65539));
    idle();
    drain();
    check("sat_sticky", sat_count, model_sat);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
